// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue between execute and the data-memory bus.
// Requests from execute are buffered in a C_DEPTH-entry FIFO and issued one at
// a time. Stores get byte-lane steering, loads get sign/zero extension on the
// way back, and misaligned halfword/word accesses are dropped with a pulse.
//
// Ports:
//   clk_i, resetb_i        clock, asynchronous active-low reset
//   clk_en_i               global advance enable
//   ex_lq_wr_i/ex_sq_wr_i  push a load / store from execute
//   ex_funct3_i            access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   ex_regd_addr_i         load destination register
//   ex_regs2_data_i        store data
//   ex_addr_i              byte address
//   ex_lq_full_o           queue full
//   dmem_*                 data-memory request/grant/response bus
//   wb_regd_*              register-file write-back
//   misaligned_o/_addr_o   misaligned-access pulse and offending address
module lsu_queue #(
  parameter int C_XLEN  = 32,
  parameter int C_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  output logic              ex_lq_full_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              wb_regd_wr_o,
  output logic [4:0]        wb_regd_addr_o,
  output logic [C_XLEN-1:0] wb_regd_data_o,
  output logic              misaligned_o,
  output logic [C_XLEN-1:0] misaligned_addr_o
);

  localparam int AW = $clog2(C_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // FIFO storage
  logic              q_store [C_DEPTH];
  logic [2:0]        q_f3    [C_DEPTH];
  logic [4:0]        q_rd    [C_DEPTH];
  logic [C_XLEN-1:0] q_data  [C_DEPTH];
  logic [C_XLEN-1:0] q_addr  [C_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic push, pop, mis_pop, ld_done, empty;

  // Head entry
  logic              h_store;
  logic [2:0]        h_f3;
  logic [4:0]        h_rd;
  logic [C_XLEN-1:0] h_data;
  logic [C_XLEN-1:0] h_addr;
  logic              h_mis;
  logic [C_XLEN-1:0] ld_shift;
  logic [C_XLEN-1:0] ld_ext;

  assign ex_lq_full_o = (count == (AW+1)'(C_DEPTH));
  assign empty        = (count == '0);
  // A push while full is dropped, regardless of a same-cycle pop.
  assign push         = clk_en_i & (ex_lq_wr_i | ex_sq_wr_i) & ~ex_lq_full_o;

  assign h_store = q_store[rd_ptr];
  assign h_f3    = q_f3[rd_ptr];
  assign h_rd    = q_rd[rd_ptr];
  assign h_data  = q_data[rd_ptr];
  assign h_addr  = q_addr[rd_ptr];

  always_comb begin
    h_mis = 1'b0;
    case (h_f3[1:0])
      2'b01:   h_mis = h_addr[0];
      2'b10:   h_mis = (h_addr[1:0] != 2'b00);
      default: h_mis = 1'b0;
    endcase
  end

  // FIFO
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < C_DEPTH; i++) begin
        q_store[i] <= 1'b0;
        q_f3[i]    <= '0;
        q_rd[i]    <= '0;
        q_data[i]  <= '0;
        q_addr[i]  <= '0;
      end
    end else begin
      if (push) begin
        q_store[wr_ptr] <= ex_sq_wr_i;
        q_f3[wr_ptr]    <= ex_funct3_i;
        q_rd[wr_ptr]    <= ex_regd_addr_i;
        q_data[wr_ptr]  <= ex_regs2_data_i;
        q_addr[wr_ptr]  <= ex_addr_i;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // FSM: next state and pop decisions; nothing moves while clk_en_i is low
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mis_pop   = 1'b0;
    ld_done   = 1'b0;
    if (clk_en_i) begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            if (h_mis) begin
              pop     = 1'b1;
              mis_pop = 1'b1;
            end else begin
              state_nxt = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt_i) begin
            if (h_store) begin
              pop       = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            pop       = 1'b1;
            ld_done   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: bus outputs, driven from the head only while requesting
  always_comb begin
    dmem_req_o   = (state == S_REQ);
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    if (state == S_REQ) begin
      dmem_we_o   = h_store;
      dmem_addr_o = {h_addr[C_XLEN-1:2], 2'b00};
      case (h_f3[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << h_addr[1:0];
          dmem_wdata_o = {4{h_data[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = 4'b0011 << {h_addr[1], 1'b0};
          dmem_wdata_o = {2{h_data[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = h_data;
        end
      endcase
    end
  end

  // Load data extraction
  assign ld_shift = dmem_rdata_i >> {h_addr[1:0], 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (h_f3)
      3'b000:  ld_ext = {{(C_XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{(C_XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {{(C_XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b101:  ld_ext = {{(C_XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Registered write-back and misaligned reporting
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wb_regd_wr_o      <= 1'b0;
      wb_regd_addr_o    <= '0;
      wb_regd_data_o    <= '0;
      misaligned_o      <= 1'b0;
      misaligned_addr_o <= '0;
    end else if (clk_en_i) begin
      wb_regd_wr_o <= ld_done & (h_rd != 5'd0);
      if (ld_done) begin
        wb_regd_addr_o <= h_rd;
        wb_regd_data_o <= ld_ext;
      end
      misaligned_o <= mis_pop;
      if (mis_pop) misaligned_addr_o <= h_addr;
    end
  end

endmodule

// File: doc/lsu_queue.md
# lsu_queue

Load/store queue downstream of the execute stage. It accepts load and store requests from execute in program order and buffers them in an in-order FIFO. It issues them one at a time on the data-memory bus, handling byte-lane steering and load sign/zero extension. Completed loads are written back to the register file.

## Interface
- C_XLEN, 32, data/address width (only 32 supported)
- C_DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  asynchronous, active-low reset
- clk_en_i  in  1  all state advances only when high
- ex_lq_wr_i  in  1  push load
- ex_sq_wr_i  in  1  push store (never together with ex_lq_wr_i)
- ex_funct3_i  in  3  access type: 0 B, 1 H, 2 W, 4 BU, 5 HU (stores use 0/1/2)
- ex_regd_addr_i  in  5  load destination register
- ex_regs2_data_i  in  C_XLEN  store data
- ex_addr_i  in  C_XLEN  byte address
- ex_lq_full_o  out  1  FIFO full, registered
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  C_XLEN  word address {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  C_XLEN  lane-steered store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  C_XLEN  load data
- wb_regd_wr_o  out  1  write-back strobe
- wb_regd_addr_o  out  5  write-back register
- wb_regd_data_o  out  C_XLEN  write-back data
- misaligned_o  out  1  misaligned-access pulse
- misaligned_addr_o  out  C_XLEN  offending address

## Operation
- FIFO entry: {is_store, funct3, regd_addr, data, addr}. Push on lq_wr|sq_wr with clk_en_i high.
- Push while ex_lq_full_o is high is dropped, even if a pop happens the same cycle. This is an assertion target.
- ex_lq_full_o = (count == C_DEPTH), taken from the registered count.
- FSM states and transitions:
  - IDLE: if FIFO is non-empty, check the head alignment.
    - Head misaligned (H with addr[0]=1; W with addr[1:0]≠0): pop, pulse misaligned_o, load misaligned_addr_o. No bus request. Stay in IDLE.
    - Otherwise, go to REQ.
  - REQ: dmem_req_o=1, with all dmem_* outputs driven from the head. On dmem_gnt_i:
    - Store: pop and go to IDLE.
    - Load: go to WAIT.
  - WAIT: on dmem_rvalid_i, pop, capture write-back, go to IDLE. dmem_rvalid_i in IDLE or REQ is ignored.
- Only one outstanding bus transaction at a time.
- Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
- Store data: B byte replicated ×4; H half replicated ×2; W unchanged.
- Load extract: shift dmem_rdata_i right by 8*addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W pass-through.
- Write-back:
  - wb_regd_wr_o pulses for one cycle, in the cycle after the rvalid edge.
  - It is suppressed when regd_addr==0; data/addr are still updated.
- Reset values: every output is 0, FIFO is empty, FSM is IDLE.
- Reset mid-transaction: the FSM returns to IDLE and the queue is flushed. Any late rvalid is ignored.
- With clk_en_i low: the FSM, FIFO and output registers hold. dmem_req_o stays asserted if in REQ, but a grant is not acted on.

## Timing
- Push at edge E0; FSM enters REQ at E1; dmem_req_o is high after E1.
- Store: gnt sampled at edge En pops; next head request at earliest En+2.
- Load: rvalid at edge Em; wb_regd_wr_o high for the cycle after Em.
- misaligned_o is high for exactly one cycle, after the edge that pops the entry.
- Full flag deasserts the cycle after the pop edge.
- dmem_* outputs stay stable while dmem_req_o is high and gnt is low.

## Test plan
- Store word: SW addr 0x100, data 0xDEADBEEF → req, we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; gnt pops; full stays 0.
- Store byte: SB addr 0x203, data 0x000000A5 → addr 0x200, be 1000, wdata 0xA5A5A5A5.
- Load sign/zero extension: rdata 0x80F0_7F81.
  - LB addr 0x3 → wb x5 = 0xFFFFFF80.
  - LBU addr 0x3 → wb = 0x00000080.
  - LH addr 0x0 → wb = 0x00007F81.
  - LHU addr 0x2 → wb = 0x000080F0.
- Full/backpressure: hold gnt low and push C_DEPTH entries → full=1.
  - A 5th push is dropped.
  - Release gnt → all 4 complete in order; full drops after the first pop.
- Misaligned: LW addr 0x102 → no req; misaligned_o one-cycle pulse with addr 0x102. The following valid SW proceeds.
- Reset mid-load: assert resetb_i in WAIT, then pulse rvalid after release → no write-back, req=0, queue empty.
- Load to x0: LW regd 0 → bus transaction completes, wb_regd_wr_o stays 0.
